seg_subtractor_zfc: RTL and testbench

//  Multi-cycle W-bit subtractor with zero detect; the difference/borrow counterpart of the

---
 rtl/seg_subtractor_zfc_if.sv | 47 ++++
 rtl/seg_subtractor_zfc.sv | 147 ++++++++++++++
 tb/tb_seg_subtractor_zfc.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/seg_subtractor_zfc_if.sv
// rtl/seg_subtractor_zfc_if.sv - operand/result handshake bundle for seg_subtractor_zfc
//
// Purpose: groups the request (a, b, bin) and response (y, bout, z[, v])
// channels of the segmented subtractor with their valid/ready pairs.
// Optional feature macro: SUB_OVF_FLAG_EN adds the signed-overflow flag v.
//
// Signals:
//   in_valid  / in_ready   request handshake
//   a, b, bin              minuend, subtrahend, borrow-in
//   out_valid / out_ready  response handshake
//   y, bout, z             difference, borrow-out, zero flag
//   v                      signed overflow (SUB_OVF_FLAG_EN only)
// Modports: master = issuing side, slave = subtractor.

interface seg_subtractor_zfc_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         bout;
    logic         z;
`ifdef SUB_OVF_FLAG_EN
    logic         v;
`endif

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, y, bout, z
`ifdef SUB_OVF_FLAG_EN
        , input v
`endif
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, y, bout, z
`ifdef SUB_OVF_FLAG_EN
        , output v
`endif
    );
endinterface

// File: rtl/seg_subtractor_zfc.sv
// rtl/seg_subtractor_zfc.sv - multi-cycle segmented W-bit subtractor with zero detect
//
// Purpose: computes y = a - b - bin one SEG-bit segment per clock, LSB first,
// with the borrow carried between segments in a register, so wide subtracts
// and compares never build a long combinational borrow chain.
// Optional feature macro: SUB_OVF_FLAG_EN adds the registered signed-overflow flag v.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   seg_subtractor_zfc_if.slave: in_valid/in_ready, a, b, bin,
//         out_valid/out_ready, y, bout, z (and v with SUB_OVF_FLAG_EN)
// Parameters: W operand width (multiple of SEG), SEG bits per clock.

module seg_subtractor_zfc #(
    parameter int W   = 64,
    parameter int SEG = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_subtractor_zfc_if.slave   bus
);
    localparam int NSEG = W / SEG;
    localparam int IW   = (NSEG > 1) ? $clog2(NSEG) : 1;

    generate
        if ((SEG < 1) || ((W % SEG) != 0)) begin : g_bad_width
            $error("seg_subtractor_zfc: W must be a positive multiple of SEG");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [W-1:0]    a_q;        // minuend, shifted down one segment per cycle
    logic [W-1:0]    nb_q;       // inverted subtrahend, shifted alongside a_q
    logic            carry_q;    // carry of a + ~b; borrow is its complement
    logic            zacc_q;     // all segments written so far are zero
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    y_q;
    logic            bout_q;
    logic            z_q;
`ifdef SUB_OVF_FLAG_EN
    logic            v_q;
`endif

    // Subtraction as a + ~b + ~bin: the segment adder always sees the
    // current lowest segment of the shifting operand registers.
    logic [SEG:0]    sum;
    logic            seg_zero;
    logic            last_seg;

    always_comb begin
        sum      = {1'b0, a_q[SEG-1:0]} + {1'b0, nb_q[SEG-1:0]} + {{SEG{1'b0}}, carry_q};
        seg_zero = (sum[SEG-1:0] == '0);
        last_seg = (idx_q == IW'(NSEG - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            nb_q        <= '0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b0;
            idx_q       <= '0;
            y_q         <= '0;
            bout_q      <= 1'b0;
            z_q         <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            v_q         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.a;
                        nb_q       <= ~bus.b;
                        carry_q    <= ~bus.bin;
                        zacc_q     <= 1'b1;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end

                RUN: begin
                    // Only the addressed segment of y changes; the rest keep
                    // the previous result until their turn comes.
                    for (int i = 0; i < NSEG; i++) begin
                        if (idx_q == IW'(i)) begin
                            y_q[i*SEG +: SEG] <= sum[SEG-1:0];
                        end
                    end
                    carry_q <= sum[SEG];
                    zacc_q  <= zacc_q & seg_zero;
                    a_q     <= a_q >> SEG;
                    nb_q    <= nb_q >> SEG;
                    idx_q   <= idx_q + IW'(1);
                    if (last_seg) begin
                        idx_q       <= '0;
                        bout_q      <= ~sum[SEG];
                        z_q         <= zacc_q & seg_zero;
`ifdef SUB_OVF_FLAG_EN
                        // Top segment: a_q[SEG-1] is a[W-1], ~nb_q[SEG-1] is b[W-1].
                        v_q         <= (a_q[SEG-1] ^ ~nb_q[SEG-1]) & (a_q[SEG-1] ^ sum[SEG-1]);
`endif
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.bout      = bout_q;
    assign bus.z         = z_q;
`ifdef SUB_OVF_FLAG_EN
    assign bus.v         = v_q;
`endif

endmodule

// File: tb/tb_seg_subtractor_zfc.sv
// tb/tb_seg_subtractor_zfc.sv - self-checking bench for seg_subtractor_zfc

module tb_seg_subtractor_zfc;
    localparam int W    = 64;
    localparam int SEG  = 8;
    localparam int NSEG = W / SEG;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_subtractor_zfc_if #(.W(W)) bus ();

    seg_subtractor_zfc #(.W(W), .SEG(SEG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] y;
        logic         bout;
        logic         z;
        logic         v;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[11];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        vec_t  r;
        logic [W:0] d;
        d      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        r.a    = a;
        r.b    = b;
        r.bin  = bin;
        r.y    = d[W-1:0];
        r.bout = d[W];
        r.z    = (d[W-1:0] == '0);
        r.v    = (a[W-1] ^ b[W-1]) & (a[W-1] ^ d[W-1]);
        return r;
    endfunction

    task automatic issue(input vec_t vin);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {63'd0, (n < 50)}, 64'd1);
        bus.a        = vin.a;
        bus.b        = vin.b;
        bus.bin      = vin.bin;
        bus.in_valid = 1'b1;
        sb.push_back(vin);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = {$urandom(), $urandom()};
        bus.b        = {$urandom(), $urandom()};
        check("in_ready_busy", {63'd0, bus.in_ready}, 64'd0);
    endtask

    task automatic collect(input int hold);
        int   lat;
        vec_t e;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 4*NSEG) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(NSEG));
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb[0];
            // Hold off the consumer while offering new operands that must be ignored.
            for (int i = 0; i < hold; i++) begin
                bus.in_valid = 1'b1;
                bus.a        = {$urandom(), $urandom()};
                bus.b        = {$urandom(), $urandom()};
                @(negedge clk);
                check("hold_y", bus.y, e.y);
                check("hold_bout", {63'd0, bus.bout}, {63'd0, e.bout});
                check("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
                check("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
            end
            bus.in_valid = 1'b0;
            e = sb.pop_front();
            check("y", bus.y, e.y);
            check("bout", {63'd0, bus.bout}, {63'd0, e.bout});
            check("z", {63'd0, bus.z}, {63'd0, e.z});
`ifdef SUB_OVF_FLAG_EN
            check("v", {63'd0, bus.v}, {63'd0, e.v});
`endif
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check("release_out_valid", {63'd0, bus.out_valid}, 64'd0);
            check("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
            check("release_y_kept", bus.y, e.y);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t e;
        //         a                         b                         bin   y                         bout  z     v
        vecs[0] = '{64'd5,                   64'd3,                    1'b0, 64'd2,                    1'b0, 1'b0, 1'b0};
        vecs[1] = '{64'd3,                   64'd5,                    1'b0, 64'hFFFF_FFFF_FFFF_FFFE,  1'b1, 1'b0, 1'b0};
        vecs[2] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF,  1'b0, 64'd0,                    1'b0, 1'b1, 1'b0};
        vecs[3] = '{64'd0,                   64'd0,                    1'b1, 64'hFFFF_FFFF_FFFF_FFFF,  1'b1, 1'b0, 1'b0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'd1,                    1'b0, 64'h7FFF_FFFF_FFFF_FFFF,  1'b0, 1'b0, 1'b1};
        vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,  1'b0, 64'h8000_0000_0000_0000,  1'b1, 1'b0, 1'b1};
        vecs[6] = '{64'h0000_0001_0000_0000, 64'd1,                    1'b0, 64'h0000_0000_FFFF_FFFF,  1'b0, 1'b0, 1'b0};
        for (int i = 7; i < 11; i++) begin
            vecs[i] = model({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_y", bus.y, 64'd0);
        check("rst_bout", {63'd0, bus.bout}, 64'd0);
        check("rst_z", {63'd0, bus.z}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // out_ready asserted while idle must not disturb anything.
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("idle_out_ready_ignored", {63'd0, bus.out_valid}, 64'd0);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i]);
            collect(0);
        end

        // Stalled consumer: result held for 10 cycles, new operands ignored.
        issue(model(64'hDEAD_BEEF_0000_1234, 64'h0000_0000_0000_1235, 1'b0));
        collect(10);
        check("sb_drained_after_hold", 64'(sb.size()), 64'd0);

        // Abort mid-RUN: async reset clears everything immediately.
        issue(model(64'h1111_2222_3333_4444, 64'h0000_0000_0000_0001, 1'b0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("abort_y", bus.y, 64'd0);
        check("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("abort_bout", {63'd0, bus.bout}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(model(64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001, 1'b1));
        collect(0);

        e = model(64'd0, 64'd0, 1'b0);
        issue(e);
        collect(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
